// File: rtl/sram_controller.sv
// sram_controller
// Processor-side bridge to a 16-bit asynchronous SRAM. Each 32-bit word
// request becomes two halfword accesses (low half first), followed by an
// idle pad, and completes with a one-cycle ready pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; ready high only while no request
// WR_LO | driving low halfword of write data, WE_N low
// WR_HI | driving high halfword of write data, WE_N low
// RD_LO | bus released, capturing low halfword into rdata[15:0]
// RD_HI | bus released, capturing high halfword into rdata[31:16]
// WAIT  | idle pad, counted down from WAIT_CYCLES-1 to terminal 0
// DONE  | ready high for one cycle, then back to IDLE
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter only needs to hold WAIT_CYCLES-1; at least one bit wide.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [16:0]   r_word;
  logic [15:0]   r_wdata_hi;
  logic [31:0]   r_rdata;
  logic [17:0]   r_sram_addr;
  logic          r_we_n;
  logic          r_dq_oe;
  logic [15:0]   r_dq_out;

  logic [16:0]   w_word_in;
  logic          w_req;
  logic [17:0]   w_addr_nxt;
  logic          w_wr_nxt;
  logic [15:0]   w_dq_nxt;

  // Word index of the incoming request; wraps silently outside the SRAM.
  assign w_word_in = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign w_req     = wr_en | rd_en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; write wins over read when both are requested
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (wr_en) begin
          w_state_nxt = S_WR_LO;
        end else if (rd_en) begin
          w_state_nxt = S_RD_LO;
        end
      end
      S_WR_LO: w_state_nxt = S_WR_HI;
      S_WR_HI: w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_RD_LO: w_state_nxt = S_RD_HI;
      S_RD_HI: w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: ready, plus next values for the registered SRAM pins.
  // In the IDLE->LO step the request fields are not latched yet, so the
  // low-half address and data come straight from the inputs.
  always_comb begin
    ready      = 1'b0;
    w_addr_nxt = r_sram_addr;
    w_wr_nxt   = 1'b0;
    w_dq_nxt   = r_dq_out;
    case (r_state)
      S_IDLE:  ready = ~w_req;
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
    case (w_state_nxt)
      S_WR_LO: begin
        w_addr_nxt = {w_word_in, 1'b0};
        w_wr_nxt   = 1'b1;
        w_dq_nxt   = wdata[15:0];
      end
      S_WR_HI: begin
        w_addr_nxt = {r_word, 1'b1};
        w_wr_nxt   = 1'b1;
        w_dq_nxt   = r_wdata_hi;
      end
      S_RD_LO: w_addr_nxt = {w_word_in, 1'b0};
      S_RD_HI: w_addr_nxt = {r_word, 1'b1};
      default: w_addr_nxt = r_sram_addr;
    endcase
  end

  // Wait pad down-counter, loaded on entry to WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt == S_WAIT && r_state != S_WAIT) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  // Latch the request when it is accepted; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word     <= '0;
      r_wdata_hi <= '0;
    end else if (r_state == S_IDLE) begin
      if (wr_en) begin
        r_word     <= w_word_in;
        r_wdata_hi <= wdata[31:16];
      end else if (rd_en) begin
        r_word <= w_word_in;
      end
    end
  end

  // Registered SRAM pins so strobes and address change together, glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
    end else begin
      r_sram_addr <= w_addr_nxt;
      r_we_n      <= ~w_wr_nxt;
      r_dq_oe     <= w_wr_nxt;
      r_dq_out    <= w_dq_nxt;
    end
  end

  // Read capture at the closing edge of each read half-access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (r_state == S_RD_LO) begin
      r_rdata[15:0] <= SRAM_DQ;
    end else if (r_state == S_RD_HI) begin
      r_rdata[31:16] <= SRAM_DQ;
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {16{1'bz}};
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = ~r_we_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default build plus a WAIT_CYCLES=0 build,
// each with a small behavioural async SRAM on its bus.
`timescale 1ns/1ps
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;

  logic        wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;

  logic        wr0, rd0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0;
  wire  [15:0] dq0;
  logic [17:0] sram_addr0;
  logic        ub0, lb0, ce0, we0, oe0;

  logic [15:0] mem  [0:255];
  logic [15:0] mem0 [0:255];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .SRAM_DQ(dq0),
    .SRAM_ADDR(sram_addr0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
    .SRAM_CE_N(ce0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0)
  );

  // Async SRAM models: write on the clock edge that closes a WE_N-low cycle,
  // read data driven whenever output enable is active.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 16'h5A00 + 16'(i);
        mem0[i] <= 16'h5A00 + 16'(i);
      end
    end else begin
      if (!SRAM_WE_N && !SRAM_CE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
      if (!we0 && !ce0) mem0[sram_addr0[7:0]] <= dq0;
    end
  end

  assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : {16{1'bz}};
  assign dq0     = (!oe0 && !ce0 && we0) ? mem0[sram_addr0[7:0]] : {16{1'bz}};

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endfunction

  // One transaction on the default build; starts at posedge+1 (cycle 0) and
  // returns at posedge+1 of the cycle after DONE with the request still held.
  task automatic run_txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                         input logic [17:0] lo, input logic [31:0] exp_rd, input bit scramble);
    wr_en = w; rd_en = r; address = a; wdata = d;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ready", {31'd0, ready}, {31'd0, c == 5});
      if (c == 1) begin
        chk("addr_lo", {14'd0, SRAM_ADDR}, {14'd0, lo});
        chk("we_n_lo", {31'd0, SRAM_WE_N}, {31'd0, !w});
        chk("oe_n_lo", {31'd0, SRAM_OE_N}, {31'd0, w});
        if (w) chk("dq_lo", {16'd0, SRAM_DQ}, {16'd0, d[15:0]});
      end
      if (c == 2) begin
        chk("addr_hi", {14'd0, SRAM_ADDR}, {14'd0, lo | 18'd1});
        chk("we_n_hi", {31'd0, SRAM_WE_N}, {31'd0, !w});
        if (w) chk("dq_hi", {16'd0, SRAM_DQ}, {16'd0, d[31:16]});
      end
      if (c == 3) chk("we_n_wait", {31'd0, SRAM_WE_N}, 32'd1);
      if (c == 5) chk("rdata", rdata, exp_rd);
      @(posedge clk); #1;
      if (scramble && c == 0) begin
        address = 32'h0000_F000;
        wdata   = 32'h1111_2222;
      end
    end
  endtask

  task automatic run0(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [17:0] lo, input logic [31:0] exp_rd);
    wr0 = w; rd0 = !w; addr0 = a; wdata0 = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ready0", {31'd0, ready0}, {31'd0, c == 3});
      if (c == 1) chk("addr0_lo", {14'd0, sram_addr0}, {14'd0, lo});
      if (c == 3) chk("rdata0", rdata0, exp_rd);
      @(posedge clk); #1;
    end
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; mem_clr = 1'b1;
    wr_en = 0; rd_en = 0; address = 0; wdata = 0;
    wr0 = 0; rd0 = 0; addr0 = 0; wdata0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("const_n", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, ub0 | lb0 | ce0}, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic write then read
    run_txn(1, 0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0, 0);
    wr_en = 0;
    chk("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    run_txn(0, 1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF, 0);
    rd_en = 0;

    // Back-to-back: write, read, read with no idle gap between DONE and next request
    run_txn(1, 0, 32'd1028, 32'h12345678, 18'd2, 32'hDEADBEEF, 0);
    run_txn(0, 1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF, 0);
    run_txn(0, 1, 32'd1028, 32'd0, 18'd2, 32'h12345678, 0);
    rd_en = 0;
    chk("mem2", {16'd0, mem[2]}, 32'h00005678);
    chk("mem3", {16'd0, mem[3]}, 32'h00001234);

    // Write priority over read, inputs scrambled after acceptance
    run_txn(1, 1, 32'd1032, 32'hA5A50F0F, 18'd4, 32'h12345678, 1);
    wr_en = 0; rd_en = 0;
    chk("mem4", {16'd0, mem[4]}, 32'h00000F0F);
    chk("mem5", {16'd0, mem[5]}, 32'h0000A5A5);

    // Reset during WR_HI: low half already written, high half must not be
    wr_en = 1; address = 32'd1036; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_mem6", {16'd0, mem[6]}, 32'h0000F00D);
    chk("abort_mem7", {16'd0, mem[7]}, 32'h00005A07);
    rst = 1'b1;
    run_txn(1, 0, 32'd1036, 32'hCAFEF00D, 18'd6, 32'd0, 0);
    wr_en = 0;
    chk("mem7", {16'd0, mem[7]}, 32'h0000CAFE);

    run_txn(0, 1, 32'd1032, 32'd0, 18'd4, 32'hA5A50F0F, 0);
    run_txn(0, 1, 32'd1036, 32'd0, 18'd6, 32'hCAFEF00D, 0);
    rd_en = 0;

    // Address wrap: below base and far above base
    run_txn(1, 0, 32'd1020, 32'h00C0FFEE, 18'h3FFFE, 32'hCAFEF00D, 0);
    wr_en = 0;
    chk("mem_fe", {16'd0, mem[8'hFE]}, 32'h0000FFEE);
    chk("mem_ff", {16'd0, mem[8'hFF]}, 32'h000000C0);
    run_txn(0, 1, 32'd1020, 32'd0, 18'h3FFFE, 32'h00C0FFEE, 0);
    run_txn(0, 1, 32'h0008_0400, 32'd0, 18'd0, 32'hDEADBEEF, 0);
    rd_en = 0;

    // Zero wait-pad build completes in cycle 3
    run0(1, 32'd1024, 32'h0BADF00D, 18'd0, 32'd0);
    chk("mem0_0", {16'd0, mem0[0]}, 32'h0000F00D);
    chk("mem0_1", {16'd0, mem0[1]}, 32'h00000BAD);
    run0(0, 32'd1024, 32'd0, 18'd0, 32'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
